// File: rtl/persp_pkg.sv
// persp_pkg: shared FSM encoding, default geometry/widths and colour constants for the perspective mapper
package persp_pkg;
  localparam int H_ACTIVE_D = 640;
  localparam int V_ACTIVE_D = 480;
  localparam int PIX_W_D = 12;
  localparam int CW_D = 79;
  localparam logic [PIX_W_D-1:0] BLACK = '0;
  typedef enum logic [1:0] {IDLE, DIV, READ, WRITE} state_t;
endpackage

// File: rtl/persp_map_engine_if.sv
// persp_map_engine_if: source-read and destination-write pixel buses of the perspective mapper
// master (engine): drives src_rd/src_addr and dst_wr/dst_addr/pixel_out, receives pixel_in
// slave (memories): the mirror image
interface persp_map_engine_if import persp_pkg::*; #(
  parameter int AW = $clog2(H_ACTIVE_D * V_ACTIVE_D),
  parameter int PIX_W = PIX_W_D
);
  logic src_rd;
  logic [AW-1:0] src_addr;
  logic [PIX_W-1:0] pixel_in;
  logic dst_wr;
  logic [AW-1:0] dst_addr;
  logic [PIX_W-1:0] pixel_out;
  modport master (output src_rd, src_addr, dst_wr, dst_addr, pixel_out, input pixel_in);
  modport slave (input src_rd, src_addr, dst_wr, dst_addr, pixel_out, output pixel_in);
endinterface

// File: rtl/persp_addr_gen.sv
// persp_addr_gen: linear frame address y*H_ACTIVE+x
// ports: x, y (pixel coordinates), addr
module persp_addr_gen #(
  parameter int H_ACTIVE = 640,
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int AW = 19
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  output logic [AW-1:0] addr
);
  assign addr = AW'(y) * AW'(H_ACTIVE) + AW'(x);
endmodule

// File: rtl/persp_div.sv
// persp_div: iterative signed restoring divider, quotient truncates toward zero
// ports: clk, reset, start (load num/den), num, den, quo (valid while ready), ready
module persp_div #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] num,
  input  logic signed [WIDTH-1:0] den,
  output logic signed [WIDTH-1:0] quo,
  output logic                    ready
);
  localparam int CNW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] q, d;
  logic [WIDTH:0] r, sh, diff;
  logic [CNW-1:0] cnt;
  logic neg;
  // partial remainder stays below d, so a borrow out of the top bit means sh < d
  assign sh = {r[WIDTH-1:0], q[WIDTH-1]};
  assign diff = sh - {1'b0, d};
  assign quo = neg ? -q : q;
  always_ff @(posedge clk) begin
    if (reset) begin
      ready <= 1'b1;
      cnt <= '0;
      q <= '0;
      d <= '0;
      r <= '0;
      neg <= 1'b0;
    end else if (start) begin
      ready <= 1'b0;
      cnt <= CNW'(WIDTH);
      q <= num[WIDTH-1] ? -num : num;
      d <= den[WIDTH-1] ? -den : den;
      r <= '0;
      neg <= num[WIDTH-1] ^ den[WIDTH-1];
    end else if (!ready) begin
      r <= diff[WIDTH] ? sh : diff;
      q <= {q[WIDTH-2:0], ~diff[WIDTH]};
      cnt <= cnt - 1'b1;
      ready <= cnt == CNW'(1);
    end
  end
endmodule

// File: rtl/persp_map_engine.sv
// persp_map_engine: renders one destination frame by inverse-homography lookup into a source frame
// ports: clk, reset, start/bypass/fill_color/p1..p9 (sampled at start), bus (src read / dst write), busy, frame_done
module persp_map_engine import persp_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int PIX_W = PIX_W_D,
  parameter int CW = CW_D,
  parameter int RD_LAT = 2,
  parameter int AW = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 bypass,
  input  logic [PIX_W-1:0]     fill_color,
  input  logic signed [CW-1:0] p1,
  input  logic signed [CW-1:0] p2,
  input  logic signed [CW-1:0] p3,
  input  logic signed [CW-1:0] p4,
  input  logic signed [CW-1:0] p5,
  input  logic signed [CW-1:0] p6,
  input  logic signed [CW-1:0] p7,
  input  logic signed [CW-1:0] p8,
  input  logic signed [CW-1:0] p9,
  persp_map_engine_if.master   bus,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  state_t st, st_n;
  logic [XW-1:0] x, sx;
  logic [YW-1:0] y, sy;
  logic signed [CW-1:0] c1, c2, c4, c5, c7, c8;
  logic signed [CW-1:0] num_x, num_y, den, row_x, row_y, row_d;
  logic signed [CW-1:0] quo_x, quo_y;
  logic [PIX_W-1:0] fill, pix;
  logic [2:0] cnt;
  logic byp, mapped, started, div_start, ready_x, ready_y, last, in_range;
  persp_div #(.WIDTH(CW)) u_div_x (
    .clk(clk), .reset(reset), .start(div_start), .num(num_x), .den(den), .quo(quo_x), .ready(ready_x)
  );
  persp_div #(.WIDTH(CW)) u_div_y (
    .clk(clk), .reset(reset), .start(div_start), .num(num_y), .den(den), .quo(quo_y), .ready(ready_y)
  );
  persp_addr_gen #(.H_ACTIVE(H_ACTIVE), .XW(XW), .YW(YW), .AW(AW)) u_src_addr (
    .x(sx), .y(sy), .addr(bus.src_addr)
  );
  persp_addr_gen #(.H_ACTIVE(H_ACTIVE), .XW(XW), .YW(YW), .AW(AW)) u_dst_addr (
    .x(x), .y(y), .addr(bus.dst_addr)
  );
  // range test on the full quotients so wrapped out-of-frame values never alias into the frame
  assign in_range = !quo_x[CW-1] && !quo_y[CW-1] &&
                    quo_x <= $signed(CW'(H_ACTIVE - 1)) && quo_y <= $signed(CW'(V_ACTIVE - 1));
  assign last = x == XW'(H_ACTIVE - 1) && y == YW'(V_ACTIVE - 1);
  assign busy = st != IDLE;
  assign bus.src_rd = st == READ && mapped && cnt == 3'd0;
  assign bus.dst_wr = st == WRITE;
  assign bus.pixel_out = pix;
  always_ff @(posedge clk) st <= reset ? IDLE : st_n;
  // started remembers that this pixel's dividers were kicked, so ready is only trusted afterwards
  always_comb begin
    st_n = st;
    div_start = 1'b0;
    case (st)
      IDLE: st_n = start && !frame_done ? DIV : IDLE;
      DIV: begin
        div_start = !byp && den != '0 && !started;
        st_n = byp || den == '0 || (started && ready_x && ready_y) ? READ : DIV;
      end
      READ: st_n = !mapped || cnt == 3'(RD_LAT) ? WRITE : READ;
      default: st_n = last ? IDLE : DIV;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done <= 1'b0;
      cnt <= '0;
      started <= 1'b0;
      x <= '0;
      y <= '0;
      sx <= '0;
      sy <= '0;
      {c1, c2, c4, c5, c7, c8} <= '0;
      {num_x, num_y, den, row_x, row_y, row_d} <= '0;
      byp <= 1'b0;
      mapped <= 1'b0;
      fill <= PIX_W'(BLACK);
      pix <= PIX_W'(BLACK);
    end else begin
      frame_done <= st == WRITE && last;
      cnt <= st == READ ? cnt + 3'd1 : 3'd0;
      started <= st_n == DIV && (started || div_start);
      if (st == IDLE && st_n == DIV) begin
        {c1, c2, c4, c5, c7, c8} <= {p1, p2, p4, p5, p7, p8};
        {num_x, row_x, num_y, row_y, den, row_d} <= {p3, p3, p6, p6, p9, p9};
        byp <= bypass;
        fill <= fill_color;
        x <= '0;
        y <= '0;
      end
      if (st == DIV && st_n == READ) begin
        sx <= byp ? x : XW'(quo_x);
        sy <= byp ? y : YW'(quo_y);
        mapped <= byp || (den != '0 && in_range);
      end
      if (st == READ && st_n == WRITE) pix <= mapped ? bus.pixel_in : fill;
      if (st == WRITE && !last) begin
        if (x != XW'(H_ACTIVE - 1)) begin
          x <= x + 1'b1;
          num_x <= num_x + c1;
          num_y <= num_y + c4;
          den <= den + c7;
        end else begin
          x <= '0;
          y <= y + 1'b1;
          row_x <= row_x + c2;
          row_y <= row_y + c5;
          row_d <= row_d + c8;
          num_x <= row_x + c2;
          num_y <= row_y + c5;
          den <= row_d + c8;
        end
      end
    end
  end
endmodule

// File: tb/tb_persp_map_engine.sv
// tb_persp_map_engine: self-checking bench with a direct-formula mapping model and memory models
module tb_persp_map_engine;
  localparam int H = 8;
  localparam int V = 4;
  localparam int N = H * V;
  localparam int RD_LAT = 2;
  localparam int AW = $clog2(N);
  logic clk = 1'b0;
  logic reset, start, bypass;
  logic [11:0] fill_color;
  logic signed [31:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic busy, frame_done;
  persp_map_engine_if #(.AW(AW), .PIX_W(12)) bus ();
  persp_map_engine #(.H_ACTIVE(H), .V_ACTIVE(V), .PIX_W(12), .CW(32), .RD_LAT(RD_LAT), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .bypass(bypass), .fill_color(fill_color),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8), .p9(p9),
    .bus(bus), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int wr_idx, rd_cnt, div_cnt, fd_cnt;
  int m_c[1:9];
  bit m_byp;
  logic [11:0] m_fill = 12'hF00;
  logic [11:0] src[N];
  logic [11:0] dst_mem[N];
  logic [11:0] pipe[RD_LAT];
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // source address the frame maps destination pixel a to, or -1 when it falls outside
  function automatic int exp_src(input int a);
    int x = a % H;
    int y = a / H;
    int nx, ny, d, sx, sy;
    if (m_byp) return a;
    nx = m_c[1] * x + m_c[2] * y + m_c[3];
    ny = m_c[4] * x + m_c[5] * y + m_c[6];
    d = m_c[7] * x + m_c[8] * y + m_c[9];
    if (d == 0) return -1;
    sx = nx / d;
    sy = ny / d;
    if (sx < 0 || sx >= H || sy < 0 || sy >= V) return -1;
    return sy * H + sx;
  endfunction
  function automatic logic [11:0] exp_pix(input int a);
    int s = exp_src(a);
    return s < 0 ? m_fill : src[s];
  endfunction
  // source memory with RD_LAT cycles of read latency
  always @(posedge clk) begin
    pipe[0] <= bus.src_rd ? src[bus.src_addr] : 12'h0;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.pixel_in = pipe[RD_LAT-1];
  always @(negedge clk) begin
    if (bus.src_rd) begin
      rd_cnt++;
      chk("src_addr", bus.src_addr, exp_src(wr_idx % N));
    end
    if (bus.dst_wr) begin
      chk("dst_addr", bus.dst_addr, wr_idx);
      chk("pixel_out", bus.pixel_out, exp_pix(wr_idx % N));
      dst_mem[bus.dst_addr] = bus.pixel_out;
      wr_idx++;
    end
    if (dut.div_start) div_cnt++;
    if (frame_done) fd_cnt++;
  end
  task automatic set_c(input int a1, a2, a3, a4, a5, a6, a7, a8, a9);
    m_c[1] = a1; m_c[2] = a2; m_c[3] = a3; m_c[4] = a4; m_c[5] = a5;
    m_c[6] = a6; m_c[7] = a7; m_c[8] = a8; m_c[9] = a9;
  endtask
  function automatic int rnd();
    return int'($urandom_range(6)) - 3;
  endfunction
  // coefficient inputs are scrambled right after start to show they are only sampled once
  task automatic start_frame();
    wr_idx = 0; rd_cnt = 0; div_cnt = 0; fd_cnt = 0;
    @(posedge clk); #1;
    p1 = m_c[1]; p2 = m_c[2]; p3 = m_c[3]; p4 = m_c[4]; p5 = m_c[5];
    p6 = m_c[6]; p7 = m_c[7]; p8 = m_c[8]; p9 = m_c[9];
    bypass = m_byp;
    fill_color = m_fill;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    p1 = $urandom; p2 = $urandom; p3 = $urandom; p4 = $urandom; p5 = $urandom;
    p6 = $urandom; p7 = $urandom; p8 = $urandom; p9 = $urandom;
    bypass = ~m_byp;
    fill_color = 12'($urandom);
  endtask
  task automatic wait_done(input bit mid);
    int n = 0;
    while (!frame_done && n < 5000) begin
      start = mid && n == 50;
      @(posedge clk); #1;
      n++;
    end
    chk("frame_done_seen", frame_done, 1);
    chk("write_count", wr_idx, N);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("frame_done_pulses", fd_cnt, 1);
  endtask
  task automatic run(input bit mid);
    start_frame();
    wait_done(mid);
  endtask
  initial begin
    int n, nwr, bad;
    reset = 1'b1; start = 1'b0; bypass = 1'b0; fill_color = 12'hF00;
    {p1, p2, p3, p4, p5, p6, p7, p8, p9} = '0;
    for (int i = 0; i < N; i++) src[i] = 12'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_dst_wr", bus.dst_wr, 0);
    chk("rst_src_rd", bus.src_rd, 0);
    chk("rst_pixel_out", bus.pixel_out, 0);
    chk("rst_dst_addr", bus.dst_addr, 0);
    reset = 1'b0;
    m_byp = 1'b0;
    set_c(1, 0, 0, 0, 1, 0, 0, 0, 1);
    run(0);
    for (int a = 0; a < N; a++) chk("identity_dst", dst_mem[a], src[a]);
    set_c(1, 0, 0, 0, 1, 0, 0, 0, 2);
    run(0);
    chk("scale_7_3", dst_mem[31], src[11]);
    chk("scale_5_0", dst_mem[5], src[2]);
    chk("scale_4_2", dst_mem[20], src[10]);
    set_c(1, 0, 100, 0, 1, 0, 0, 0, 1);
    run(0);
    chk("translate_reads", rd_cnt, 0);
    bad = 0;
    for (int a = 0; a < N; a++) bad += int'(dst_mem[a] != 12'hF00);
    chk("translate_fill", bad, 0);
    set_c(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run(0);
    chk("zero_div_starts", div_cnt, 0);
    chk("zero_reads", rd_cnt, 0);
    chk("zero_fill_last", dst_mem[N-1], 12'hF00);
    set_c(-1, 0, 7, 0, 1, 0, 0, 0, 1);
    run(1);
    chk("mirror_0_0", dst_mem[0], src[7]);
    chk("mirror_1_1", dst_mem[9], src[14]);
    chk("mirror_7_3", dst_mem[31], src[24]);
    m_byp = 1'b1;
    set_c(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), 0);
    run(0);
    chk("bypass_div_starts", div_cnt, 0);
    m_byp = 1'b0;
    repeat (3) begin
      set_c(rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), int'($urandom_range(6)) - 1);
      run(0);
    end
    set_c(1, 0, 0, 0, 1, 0, 0, 0, 1);
    start_frame();
    n = 0;
    while (!(bus.dst_wr && bus.dst_addr == 10) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_pixel_10", bus.dst_wr, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    nwr = wr_idx;
    chk("abort_busy", busy, 0);
    chk("abort_dst_wr", bus.dst_wr, 0);
    chk("abort_src_rd", bus.src_rd, 0);
    chk("abort_pixel_out", bus.pixel_out, 0);
    chk("abort_dst_addr", bus.dst_addr, 0);
    chk("abort_src_addr", bus.src_addr, 0);
    repeat (50) @(posedge clk);
    #1;
    chk("abort_no_writes", wr_idx, nwr);
    chk("abort_no_done", fd_cnt, 0);
    run(0);
    bad = 0;
    for (int a = 0; a < N; a++) bad += int'(dst_mem[a] != src[a]);
    chk("restart_identity", bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
